// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART receive / word-packing path.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

  // Bus and counter widths are derived from module parameters, so they live here as helpers.
  function automatic int bus_width(input int n_words, input int bits_per_word);
    return n_words * bits_per_word;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Bit-level UART receiver: 2-flop synchroniser, mid-bit sampling FSM, parity and stop checks.
// Word and error flags are registered, valid one cycle after the last stop sample; no backpressure.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] word,
  output logic                     word_valid,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     idle
);

  localparam int CW = cnt_width(CLOCKS_PER_PULSE);
  localparam int BW = cnt_width(BITS_PER_WORD);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_WORD - 1);
  localparam bit HAS_PARITY = (PARITY != int'(NONE));
  localparam bit IS_EVEN    = (PARITY == int'(EVEN));

  logic                     rx_meta;
  logic                     rx_s;
  rx_state_e                state;
  logic [CW-1:0]            cnt;
  logic [BW-1:0]            bit_idx;
  logic                     stop_idx;
  logic [BITS_PER_WORD-1:0] shreg;
  logic                     par_acc;
  logic                     par_bad;
  logic                     frm_bad;
  logic                     sample;
  logic                     last_stop;
  logic                     stop_bad;

  always_comb begin
    sample    = (state == ST_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);
    last_stop = (STOP_BITS == 1) || stop_idx;
    stop_bad  = frm_bad || !rx_s;
    idle      = (state == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      frm_bad    <= 1'b0;
      word       <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      if (state == ST_IDLE || sample) cnt <= '0;
      else                            cnt <= cnt + CW'(1);

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state    <= ST_START;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            frm_bad  <= 1'b0;
          end
        end
        ST_START: begin
          // A start bit that has gone high by mid-bit is a glitch, not a frame.
          if (sample) state <= rx_s ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (sample) begin
            shreg   <= BITS_PER_WORD'({rx_s, shreg} >> 1);
            par_acc <= par_acc ^ rx_s;
            if (bit_idx == LAST_BIT) state <= HAS_PARITY ? ST_PAR : ST_STOP;
            else                     bit_idx <= bit_idx + BW'(1);
          end
        end
        ST_PAR: begin
          if (sample) begin
            par_bad <= IS_EVEN ? (rx_s != par_acc) : (rx_s == par_acc);
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample) begin
            if (last_stop) begin
              state      <= ST_IDLE;
              word       <= shreg;
              word_valid <= !stop_bad && !par_bad;
              frame_err  <= stop_bad;
              parity_err <= par_bad;
            end else begin
              frm_bad  <= stop_bad;
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_packer.sv
// Packs N_WORDS UART words into one wide beat; m_valid rises the cycle after the last word commits.
// Output is a single valid/ready register; a packet completing while it is occupied is dropped.
module uart_rx_packer
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int N_WORDS          = 6,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int TIMEOUT_PULSES   = 32
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                rx,
  output logic [N_WORDS*BITS_PER_WORD-1:0]    m_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                err_frame,
  output logic                                err_parity,
  output logic                                err_timeout,
  output logic                                err_overflow,
  output logic                                busy
);

  localparam int W_BUS     = bus_width(N_WORDS, BITS_PER_WORD);
  localparam int W_WCNT    = cnt_width(N_WORDS);
  localparam int TMO_LIMIT = TIMEOUT_PULSES * CLOCKS_PER_PULSE;
  localparam int TW        = cnt_width(TMO_LIMIT + 1);
  localparam bit TMO_EN    = (TMO_LIMIT > 0);
  localparam logic [W_WCNT-1:0] LAST_SLOT = W_WCNT'(N_WORDS - 1);
  localparam logic [TW-1:0]     TMO_LAST  = TW'(TMO_LIMIT - 1);

  logic [BITS_PER_WORD-1:0] word;
  logic                     word_valid;
  logic                     core_idle;
  logic [W_BUS-1:0]         asm_q;
  logic [W_BUS-1:0]         pkt_next;
  logic [W_WCNT-1:0]        word_cnt;
  logic [TW-1:0]            tmo_cnt;
  logic                     tmo_run;
  logic                     out_free;

  uart_rx_core #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
    .BITS_PER_WORD   (BITS_PER_WORD),
    .PARITY          (PARITY),
    .STOP_BITS       (STOP_BITS)
  ) u_core (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .word      (word),
    .word_valid(word_valid),
    .frame_err (err_frame),
    .parity_err(err_parity),
    .idle      (core_idle)
  );

  // Assembly buffer with the incoming word already dropped into its slot.
  always_comb begin
    pkt_next = asm_q;
    for (int i = 0; i < N_WORDS; i++) begin
      if (word_cnt == W_WCNT'(i)) pkt_next[i*BITS_PER_WORD +: BITS_PER_WORD] = word;
    end
  end

  always_comb begin
    tmo_run  = TMO_EN && core_idle && (word_cnt != '0);
    out_free = !m_valid || m_ready;
    busy     = !core_idle || (word_cnt != '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      asm_q        <= '0;
      word_cnt     <= '0;
      tmo_cnt      <= '0;
      m_data       <= '0;
      m_valid      <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
      if (m_valid && m_ready) m_valid <= 1'b0;

      if (word_valid) begin
        asm_q   <= pkt_next;
        tmo_cnt <= '0;
        if (word_cnt == LAST_SLOT) begin
          word_cnt <= '0;
          if (out_free) begin
            m_data  <= pkt_next;
            m_valid <= 1'b1;
          end else begin
            err_overflow <= 1'b1;
          end
        end else begin
          word_cnt <= word_cnt + W_WCNT'(1);
        end
      end else if (err_frame || err_parity) begin
        word_cnt <= '0;
        tmo_cnt  <= '0;
      end else if (tmo_run) begin
        if (tmo_cnt == TMO_LAST) begin
          word_cnt    <= '0;
          tmo_cnt     <= '0;
          err_timeout <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Scoreboard bench: two packers (no parity / even parity) driven by directed UART frames.
module tb_uart_rx_packer;

  localparam int CPP = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx0, rx1;
  logic        m_ready0, m_ready1;
  logic [47:0] m_data0, m_data1;
  logic        m_valid0, m_valid1;
  logic        ef0, ep0, et0, eo0, busy0;
  logic        ef1, ep1, et1, eo1, busy1;

  always #5 clk = ~clk;

  uart_rx_packer #(
    .CLOCKS_PER_PULSE(4), .BITS_PER_WORD(8), .N_WORDS(6),
    .PARITY(0), .STOP_BITS(1), .TIMEOUT_PULSES(32)
  ) dut (
    .clk(clk), .rstn(rstn), .rx(rx0),
    .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0),
    .err_frame(ef0), .err_parity(ep0), .err_timeout(et0), .err_overflow(eo0),
    .busy(busy0)
  );

  uart_rx_packer #(
    .CLOCKS_PER_PULSE(4), .BITS_PER_WORD(8), .N_WORDS(6),
    .PARITY(1), .STOP_BITS(1), .TIMEOUT_PULSES(32)
  ) dut_p (
    .clk(clk), .rstn(rstn), .rx(rx1),
    .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1),
    .err_frame(ef1), .err_parity(ep1), .err_timeout(et1), .err_overflow(eo1),
    .busy(busy1)
  );

  int checks = 0;
  int failures = 0;
  logic [47:0] exp_q0[$];
  logic [47:0] exp_q1[$];
  int n_frame[2], n_par[2], n_tmo[2], n_ovf[2], n_vld[2], n_hs[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int err_sum(input int s);
    return n_frame[s] + n_par[s] + n_tmo[s] + n_ovf[s];
  endfunction

  // Monitors: compare every presented beat against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (ef0) n_frame[0]++;
      if (ep0) n_par[0]++;
      if (et0) n_tmo[0]++;
      if (eo0) n_ovf[0]++;
      if (m_valid0) begin
        n_vld[0]++;
        if (exp_q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL pkt0_unexpected: got %0h expected no packet", m_data0);
        end else begin
          check("pkt0", {16'h0, m_data0}, {16'h0, exp_q0[0]});
          if (m_ready0) begin
            void'(exp_q0.pop_front());
            n_hs[0]++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (ef1) n_frame[1]++;
      if (ep1) n_par[1]++;
      if (et1) n_tmo[1]++;
      if (eo1) n_ovf[1]++;
      if (m_valid1) begin
        n_vld[1]++;
        if (exp_q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL pkt1_unexpected: got %0h expected no packet", m_data1);
        end else begin
          check("pkt1", {16'h0, m_data1}, {16'h0, exp_q1[0]});
          if (m_ready1) begin
            void'(exp_q1.pop_front());
            n_hs[1]++;
          end
        end
      end
    end
  end

  task automatic drive_bit(input bit sel, input logic v, input int cyc);
    if (sel) rx1 = v; else rx0 = v;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  // par < 0: no parity bit. A bad stop bit is released one cycle early so the
  // receiver does not see the still-low line as a fresh start bit.
  task automatic send_frame(input bit sel, input logic [7:0] d, input int par, input logic stop);
    drive_bit(sel, 1'b0, CPP);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], CPP);
    if (par >= 0) drive_bit(sel, par[0], CPP);
    if (stop) drive_bit(sel, 1'b1, CPP);
    else begin
      drive_bit(sel, 1'b0, CPP - 1);
      drive_bit(sel, 1'b1, 1);
    end
  endtask

  task automatic send_bytes(input bit sel, input logic [7:0] b [6], input bit par_en);
    for (int i = 0; i < 6; i++) send_frame(sel, b[i], par_en ? int'(^b[i]) : -1, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, v0, h0, f0, o0, t0, h1, p1, e1;
    logic [7:0] bytes [6];
    for (int s = 0; s < 2; s++) begin
      n_frame[s] = 0; n_par[s] = 0; n_tmo[s] = 0; n_ovf[s] = 0; n_vld[s] = 0; n_hs[s] = 0;
    end
    rstn = 1'b0; rx0 = 1'b1; rx1 = 1'b1; m_ready0 = 1'b1; m_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", {63'h0, m_valid0}, 64'h0);
    check("rst_m_data", {16'h0, m_data0}, 64'h0);
    check("rst_busy", {63'h0, busy0}, 64'h0);
    check("rst_errs", {60'h0, ef0, ep0, et0, eo0}, 64'h0);
    check("rst_p_valid_busy", {62'h0, m_valid1, busy1}, 64'h0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Nominal packet, consumer always ready.
    e0 = err_sum(0); v0 = n_vld[0]; h0 = n_hs[0];
    exp_q0.push_back(48'h060504030201);
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_bytes(1'b0, bytes, 1'b0);
    drive_bit(1'b0, 1'b1, 20);
    check("nom_valid_cycles", 64'(n_vld[0] - v0), 64'd1);
    check("nom_handshakes", 64'(n_hs[0] - h0), 64'd1);
    check("nom_errs", 64'(err_sum(0) - e0), 64'd0);

    // Backpressure: second packet overflows, first stays held.
    m_ready0 = 1'b0;
    o0 = n_ovf[0]; h0 = n_hs[0];
    exp_q0.push_back(48'h161514131211);
    bytes = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    send_bytes(1'b0, bytes, 1'b0);
    bytes = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    send_bytes(1'b0, bytes, 1'b0);
    drive_bit(1'b0, 1'b1, 20);
    check("bp_overflow", 64'(n_ovf[0] - o0), 64'd1);
    check("bp_no_hs_yet", 64'(n_hs[0] - h0), 64'd0);
    check("bp_valid_held", {63'h0, m_valid0}, 64'h1);
    m_ready0 = 1'b1;
    drive_bit(1'b0, 1'b1, 3);
    check("bp_one_hs", 64'(n_hs[0] - h0), 64'd1);
    check("bp_valid_low", {63'h0, m_valid0}, 64'h0);

    // Framing error on the third word discards the partial packet.
    f0 = n_frame[0]; e0 = err_sum(0); h0 = n_hs[0];
    exp_q0.push_back(48'hA5A4A3A2A1A0);
    send_frame(1'b0, 8'h50, -1, 1'b1);
    send_frame(1'b0, 8'h51, -1, 1'b1);
    send_frame(1'b0, 8'h52, -1, 1'b0);
    drive_bit(1'b0, 1'b1, 2 * CPP);
    check("frm_pulse", 64'(n_frame[0] - f0), 64'd1);
    check("frm_no_pkt", 64'(n_hs[0] - h0), 64'd0);
    bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_bytes(1'b0, bytes, 1'b0);
    drive_bit(1'b0, 1'b1, 20);
    check("frm_recover_hs", 64'(n_hs[0] - h0), 64'd1);
    check("frm_only_err", 64'(err_sum(0) - e0), 64'd1);

    // Even parity: bad parity on 0x07 drops the two words before it.
    p1 = n_par[1]; e1 = err_sum(1); h1 = n_hs[1];
    exp_q1.push_back(48'h554433221107);
    send_frame(1'b1, 8'h10, 1, 1'b1);
    send_frame(1'b1, 8'h20, 1, 1'b1);
    send_frame(1'b1, 8'h07, 0, 1'b1);
    drive_bit(1'b1, 1'b1, 2 * CPP);
    check("par_pulse", 64'(n_par[1] - p1), 64'd1);
    check("par_no_pkt", 64'(n_hs[1] - h1), 64'd0);
    bytes = '{8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_bytes(1'b1, bytes, 1'b1);
    drive_bit(1'b1, 1'b1, 20);
    check("par_good_hs", 64'(n_hs[1] - h1), 64'd1);
    check("par_only_err", 64'(err_sum(1) - e1), 64'd1);

    // One-cycle glitch: briefly busy, then idle with no error.
    e0 = err_sum(0); h0 = n_hs[0];
    drive_bit(1'b0, 1'b0, 1);
    drive_bit(1'b0, 1'b1, 2);
    check("glitch_busy_hi", {63'h0, busy0}, 64'h1);
    drive_bit(1'b0, 1'b1, 5);
    check("glitch_busy_lo", {63'h0, busy0}, 64'h0);
    exp_q0.push_back(48'hC6C5C4C3C2C1);
    bytes = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
    send_bytes(1'b0, bytes, 1'b0);
    drive_bit(1'b0, 1'b1, 20);
    check("glitch_pkt_hs", 64'(n_hs[0] - h0), 64'd1);
    check("glitch_errs", 64'(err_sum(0) - e0), 64'd0);

    // Partial packet timeout after 32 bit-times of idle.
    t0 = n_tmo[0]; h0 = n_hs[0];
    send_frame(1'b0, 8'h31, -1, 1'b1);
    send_frame(1'b0, 8'h32, -1, 1'b1);
    send_frame(1'b0, 8'h33, -1, 1'b1);
    drive_bit(1'b0, 1'b1, 100);
    check("tmo_busy_partial", {63'h0, busy0}, 64'h1);
    check("tmo_not_yet", 64'(n_tmo[0] - t0), 64'd0);
    drive_bit(1'b0, 1'b1, 60);
    check("tmo_pulse", 64'(n_tmo[0] - t0), 64'd1);
    check("tmo_wordcnt_clr", {63'h0, busy0}, 64'h0);
    exp_q0.push_back(48'h464544434241);
    bytes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    send_bytes(1'b0, bytes, 1'b0);
    drive_bit(1'b0, 1'b1, 20);
    check("tmo_aligned_hs", 64'(n_hs[0] - h0), 64'd1);
    check("tmo_single", 64'(n_tmo[0] - t0), 64'd1);

    // Reset mid-word: nothing of the partial packet survives.
    e0 = err_sum(0); h0 = n_hs[0];
    send_frame(1'b0, 8'h77, -1, 1'b1);
    send_frame(1'b0, 8'h78, -1, 1'b1);
    drive_bit(1'b0, 1'b0, CPP);
    drive_bit(1'b0, 1'b1, 3 * CPP);
    rstn = 1'b0;
    #1;
    check("rst_mid_busy", {63'h0, busy0}, 64'h0);
    check("rst_mid_valid", {63'h0, m_valid0}, 64'h0);
    rx0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    drive_bit(1'b0, 1'b1, 2 * CPP);
    exp_q0.push_back(48'h868584838281);
    bytes = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86};
    send_bytes(1'b0, bytes, 1'b0);
    drive_bit(1'b0, 1'b1, 20);
    check("rst_mid_pkt_hs", 64'(n_hs[0] - h0), 64'd1);
    check("rst_mid_errs", 64'(err_sum(0) - e0), 64'd0);

    check("q0_drained", 64'(exp_q0.size()), 64'd0);
    check("q1_drained", 64'(exp_q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
